// File: rtl/itch_msg_encoder_pkg.sv
// itch_msg_encoder_pkg: ITCH message constants, lengths and encoder FSM state type
package itch_msg_encoder_pkg;
  localparam int MAX_LEN = 26;
  localparam int CNT_W = 5;
  localparam int IMG_W = MAX_LEN * 8;
  localparam logic [7:0] ITCH_ADD = 8'h41;
  localparam logic [7:0] ITCH_CANCEL = 8'h58;
  localparam logic [7:0] ITCH_DELETE = 8'h44;
  localparam logic [7:0] ITCH_REPLACE = 8'h55;
  localparam logic [7:0] SIDE_BUY = 8'h42;
  localparam logic [7:0] SIDE_SELL = 8'h53;
  localparam logic [CNT_W-1:0] LEN_ADD = 5'd26;
  localparam logic [CNT_W-1:0] LEN_CANCEL = 5'd13;
  localparam logic [CNT_W-1:0] LEN_DELETE = 5'd9;
  localparam logic [CNT_W-1:0] LEN_REPLACE = 5'd25;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/itch_msg_encoder_packer.sv
// itch_msg_encoder_packer: maps a decoded order event onto a left-justified big-endian byte image
module itch_msg_encoder_packer
  import itch_msg_encoder_pkg::*;
(
  input  logic [7:0]       msg_type,
  input  logic [63:0]      order_ref,
  input  logic [63:0]      new_ref,
  input  logic             buy_sell,
  input  logic [31:0]      shares,
  input  logic [31:0]      price,
  input  logic [63:0]      stock_symbol,
  output logic [CNT_W-1:0] len,
  output logic             known,
  output logic [IMG_W-1:0] image
);
  always_comb begin
    len = '0;
    known = 1'b1;
    image = '0;
    case (msg_type)
      ITCH_ADD: begin
        len = LEN_ADD;
        image = {msg_type, order_ref, buy_sell ? SIDE_BUY : SIDE_SELL, shares, stock_symbol, price};
      end
      ITCH_CANCEL: begin
        len = LEN_CANCEL;
        image = {msg_type, order_ref, shares, 104'd0};
      end
      ITCH_DELETE: begin
        len = LEN_DELETE;
        image = {msg_type, order_ref, 136'd0};
      end
      ITCH_REPLACE: begin
        len = LEN_REPLACE;
        image = {msg_type, order_ref, new_ref, shares, price, 8'd0};
      end
      default: known = 1'b0;
    endcase
  end
endmodule

// File: rtl/itch_msg_encoder.sv
// itch_msg_encoder: serialises one order event per command into an ITCH byte stream
module itch_msg_encoder
  import itch_msg_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  msg_type,
  input  logic [63:0] order_ref,
  input  logic [63:0] new_ref,
  input  logic        buy_sell,
  input  logic [31:0] shares,
  input  logic [31:0] price,
  input  logic [63:0] stock_symbol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_start,
  output logic        out_last,
  output logic        err_unsupported
);
  state_t state, state_next;
  logic [IMG_W-1:0] shreg, image;
  logic [CNT_W-1:0] cnt, len;
  logic known, first, err, accept, fire;

  itch_msg_encoder_packer u_packer (
    .msg_type(msg_type), .order_ref(order_ref), .new_ref(new_ref), .buy_sell(buy_sell),
    .shares(shares), .price(price), .stock_symbol(stock_symbol),
    .len(len), .known(known), .image(image)
  );

  assign out_valid = state == SEND;
  assign out_byte = shreg[IMG_W-1 -: 8];
  assign out_start = out_valid && first;
  assign out_last = out_valid && cnt == '0;
  assign fire = out_valid && out_ready;
  // Accepting on the last-byte handshake gives zero-bubble back-to-back messages
  assign cmd_ready = !out_valid || (fire && out_last);
  assign accept = cmd_valid && cmd_ready;
  assign err_unsupported = err;

  always_comb begin
    state_next = accept ? (known ? SEND : IDLE) : (fire && out_last) ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt <= '0;
      first <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= accept && !known;
      if (accept && known) begin
        shreg <= image;
        cnt <= len - 1'b1;
        first <= 1'b1;
      end else if (fire) begin
        shreg <= shreg << 8;
        first <= 1'b0;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_itch_msg_encoder.sv
// tb_itch_msg_encoder: randomized scoreboard bench with a byte-list reference model
module tb_itch_msg_encoder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [7:0] msg_type = 8'h00;
  logic [63:0] order_ref = '0, new_ref = '0, stock_symbol = '0;
  logic buy_sell = 1'b0;
  logic [31:0] shares = '0, price = '0;
  logic out_valid, out_ready = 1'b1, out_start, out_last, err_unsupported;
  logic [7:0] out_byte;

  itch_msg_encoder dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .msg_type(msg_type), .order_ref(order_ref), .new_ref(new_ref), .buy_sell(buy_sell),
    .shares(shares), .price(price), .stock_symbol(stock_symbol),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_start(out_start), .out_last(out_last), .err_unsupported(err_unsupported)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, err_pend = 0, nfired = 0, last_cyc = 0, gap = 0;
  bit stall_mode = 1'b0, held = 1'b0;
  logic [10:0] prev;
  logic [9:0] exp_q[$];
  int acc_q[$];
  logic [7:0] mb[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic add(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mb.push_back(v[8*i +: 8]);
  endtask

  // Reference: message = type byte followed by the listed fields, MSB byte first
  task automatic model(input logic [7:0] t);
    mb.delete();
    mb.push_back(t);
    case (t)
      "A": begin
        add(order_ref, 8); mb.push_back(buy_sell ? "B" : "S");
        add(64'(shares), 4); add(stock_symbol, 8); add(64'(price), 4);
      end
      "X": begin add(order_ref, 8); add(64'(shares), 4); end
      "D": add(order_ref, 8);
      "U": begin add(order_ref, 8); add(new_ref, 8); add(64'(shares), 4); add(64'(price), 4); end
      default: begin err_pend++; return; end
    endcase
    for (int i = 0; i < mb.size(); i++) exp_q.push_back({i == 0, i == mb.size() - 1, mb[i]});
  endtask

  task automatic rnd_fields();
    order_ref = {$urandom, $urandom}; new_ref = {$urandom, $urandom};
    stock_symbol = {$urandom, $urandom}; buy_sell = 1'($urandom);
    shares = $urandom; price = $urandom;
  endtask

  task automatic send(input logic [7:0] t);
    bit ok = 1'b0;
    int a = 0;
    @(negedge clk);
    msg_type = t;
    cmd_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      #1;
      ok = cmd_ready;
      a = cyc;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      model(t);
      if (t == "A" || t == "X" || t == "D" || t == "U") acc_q.push_back(a);
    end
    #1;
    cmd_valid = 1'b0;
    rnd_fields();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain_queue_empty", 64'(exp_q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) held = 1'b0;
    else begin
      if (held) chk("stall_stable", {out_valid, out_start, out_last, out_byte}, prev);
      if (out_valid && out_start && !held) begin
        if (acc_q.size() == 0) chk("unexpected_start", 1, 0);
        else chk("first_byte_latency", 64'(cyc), 64'(acc_q.pop_front() + 1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_byte", {out_start, out_last, out_byte}, 0);
        else chk("byte_flags", {out_start, out_last, out_byte}, exp_q.pop_front());
        if (out_start) gap = cyc - last_cyc;
        if (out_last) begin
          chk("cmd_ready_on_last", cmd_ready, 1);
          last_cyc = cyc;
        end
        nfired++;
      end
      if (err_unsupported) begin
        chk("err_expected", err_pend > 0, 1);
        chk("err_no_valid", out_valid, 0);
        if (err_pend > 0) err_pend--;
      end
      held = out_valid && !out_ready;
      prev = {out_valid, out_start, out_last, out_byte};
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_start, out_last, err_unsupported, out_byte}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    order_ref = 64'h0102030405060708;
    send("D");
    drain();
    order_ref = 64'h1112131415161718; buy_sell = 1'b1; shares = 100;
    stock_symbol = 64'h4141504C20202020; price = 32'h000F4240;
    send("A");
    drain();
    send("X");
    send("U");
    drain();
    chk("back_to_back_gap", 64'(gap), 1);
    stall_mode = 1'b1;
    send("U");
    drain();
    stall_mode = 1'b0;
    send("Z");
    send("D");
    drain();
    nfired = 0;
    send("A");
    for (int i = 0; i < 200 && nfired < 5; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {out_valid, out_start, out_last, err_unsupported, out_byte}, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send("X");
    drain();
    for (int k = 0; k < 150; k++) begin
      stall_mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: send("A");
        1: send("X");
        2: send("D");
        3: send("U");
        4: send("Z");
        default: send(8'($urandom));
      endcase
    end
    stall_mode = 1'b0;
    drain();
    chk("err_all_seen", 64'(err_pend), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
